// File: rtl/dsp_chain_sop_param.sv
// Parametrised pipelined chain of signed two-product sum-of-products stages.
// Stage k sees its operands through a k-deep skew line, so one sample's partial
// sums meet along the registered cascade. A framed accumulator sums the chain
// output over each frame and reports sticky signed overflow with the result.
module dsp_chain_sop_param #(
  parameter int unsigned NUM_STAGES = 4,
  parameter int unsigned X_W        = 18,
  parameter int unsigned Y_W        = 19,
  parameter int unsigned CHAIN_W    = 40,
  parameter int unsigned ACC_W      = 48
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  input  logic                        in_first,
  input  logic                        in_last,
  input  logic [NUM_STAGES*X_W-1:0]   ax,
  input  logic [NUM_STAGES*X_W-1:0]   bx,
  input  logic [NUM_STAGES*Y_W-1:0]   ay,
  input  logic [NUM_STAGES*Y_W-1:0]   by,
  output logic                        out_valid,
  output logic [ACC_W-1:0]            result,
  output logic                        overflow
);

  // One sign bit of headroom for the two-product sum.
  localparam int unsigned ProdW = X_W + Y_W + 1;

  // ---------------------------------------------------------------------------
  // SOP stages with operand skew and registered cascade
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    logic signed [X_W-1:0]         ax_k, bx_k;
    logic signed [Y_W-1:0]         ay_k, by_k;
    logic signed [X_W+Y_W-1:0]     pa, pb;
    logic signed [ProdW-1:0]       p;
    logic signed [CHAIN_W-1:0]     p_ext;
    logic signed [CHAIN_W-1:0]     s_prev;
    logic signed [CHAIN_W-1:0]     s_d, s_q;

    if (k == 0) begin : g_head
      // Stage 0 consumes the inputs directly; the cascade starts from zero.
      assign ax_k   = ax[X_W-1:0];
      assign bx_k   = bx[X_W-1:0];
      assign ay_k   = ay[Y_W-1:0];
      assign by_k   = by[Y_W-1:0];
      assign s_prev = '0;
    end else begin : g_link
      logic [X_W-1:0] ax_sk_d [k];
      logic [X_W-1:0] ax_sk_q [k];
      logic [X_W-1:0] bx_sk_d [k];
      logic [X_W-1:0] bx_sk_q [k];
      logic [Y_W-1:0] ay_sk_d [k];
      logic [Y_W-1:0] ay_sk_q [k];
      logic [Y_W-1:0] by_sk_d [k];
      logic [Y_W-1:0] by_sk_q [k];

      // Skew line next state: shift in this stage's slice every cycle.
      always_comb begin
        ax_sk_d[0] = ax[k*X_W +: X_W];
        bx_sk_d[0] = bx[k*X_W +: X_W];
        ay_sk_d[0] = ay[k*Y_W +: Y_W];
        by_sk_d[0] = by[k*Y_W +: Y_W];
        for (int i = 1; i < k; i++) begin
          ax_sk_d[i] = ax_sk_q[i-1];
          bx_sk_d[i] = bx_sk_q[i-1];
          ay_sk_d[i] = ay_sk_q[i-1];
          by_sk_d[i] = by_sk_q[i-1];
        end
      end

      // Skew line registers, loaded regardless of valid.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int i = 0; i < k; i++) begin
            ax_sk_q[i] <= '0;
            bx_sk_q[i] <= '0;
            ay_sk_q[i] <= '0;
            by_sk_q[i] <= '0;
          end
        end else begin
          for (int i = 0; i < k; i++) begin
            ax_sk_q[i] <= ax_sk_d[i];
            bx_sk_q[i] <= bx_sk_d[i];
            ay_sk_q[i] <= ay_sk_d[i];
            by_sk_q[i] <= by_sk_d[i];
          end
        end
      end

      assign ax_k   = ax_sk_q[k-1];
      assign bx_k   = bx_sk_q[k-1];
      assign ay_k   = ay_sk_q[k-1];
      assign by_k   = by_sk_q[k-1];
      assign s_prev = g_stage[k-1].s_q;
    end

    assign pa    = ax_k * ay_k;
    assign pb    = bx_k * by_k;
    assign p     = ProdW'(pa) + ProdW'(pb);
    assign p_ext = CHAIN_W'(p);

    // Cascade next state: this stage's products plus the upstream partial sum.
    always_comb begin
      s_d = p_ext + s_prev;
    end

    // Cascade register.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        s_q <= '0;
      end else begin
        s_q <= s_d;
      end
    end
  end

  logic signed [CHAIN_W-1:0] chain_tail;
  assign chain_tail = g_stage[NUM_STAGES-1].s_q;

  // ---------------------------------------------------------------------------
  // Sideband pipeline, aligned with the last cascade register
  // ---------------------------------------------------------------------------
  logic [NUM_STAGES-1:0] sb_vld_d, sb_vld_q;
  logic [NUM_STAGES-1:0] sb_fst_d, sb_fst_q;
  logic [NUM_STAGES-1:0] sb_lst_d, sb_lst_q;

  // Sideband next state: plain shift line.
  always_comb begin
    sb_vld_d    = '0;
    sb_fst_d    = '0;
    sb_lst_d    = '0;
    sb_vld_d[0] = in_valid;
    sb_fst_d[0] = in_first;
    sb_lst_d[0] = in_last;
    for (int i = 1; i < NUM_STAGES; i++) begin
      sb_vld_d[i] = sb_vld_q[i-1];
      sb_fst_d[i] = sb_fst_q[i-1];
      sb_lst_d[i] = sb_lst_q[i-1];
    end
  end

  // Sideband registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sb_vld_q <= '0;
      sb_fst_q <= '0;
      sb_lst_q <= '0;
    end else begin
      sb_vld_q <= sb_vld_d;
      sb_fst_q <= sb_fst_d;
      sb_lst_q <= sb_lst_d;
    end
  end

  logic al_vld, al_fst, al_lst;
  assign al_vld = sb_vld_q[NUM_STAGES-1];
  assign al_fst = sb_fst_q[NUM_STAGES-1];
  assign al_lst = sb_lst_q[NUM_STAGES-1];

  // ---------------------------------------------------------------------------
  // Framed accumulator and result registers
  // ---------------------------------------------------------------------------
  logic signed [ACC_W-1:0] chain_ext;
  logic        [ACC_W-1:0] acc_sum;
  logic                    add_ovf;
  logic        [ACC_W-1:0] acc_d, acc_q;
  logic                    ovf_d, ovf_q;
  logic                    out_valid_d, out_valid_q;
  logic        [ACC_W-1:0] result_d, result_q;
  logic                    overflow_d, overflow_q;

  assign chain_ext = ACC_W'(chain_tail);
  assign acc_sum   = acc_q + chain_ext;
  // Signed overflow: operands agree in sign but the wrapped sum does not.
  assign add_ovf   = (acc_q[ACC_W-1] == chain_ext[ACC_W-1]) &&
                     (acc_sum[ACC_W-1] != acc_q[ACC_W-1]);

  // Accumulator next state; invalid samples leave everything untouched.
  always_comb begin
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    out_valid_d = 1'b0;
    result_d    = result_q;
    overflow_d  = overflow_q;
    if (al_vld) begin
      if (al_fst) begin
        acc_d = chain_ext;
        ovf_d = 1'b0;
      end else begin
        acc_d = acc_sum;
        ovf_d = ovf_q | add_ovf;
      end
      if (al_lst) begin
        out_valid_d = 1'b1;
        result_d    = acc_d;
        overflow_d  = ovf_d;
      end
    end
  end

  // Accumulator, sticky flag and held result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      overflow_q  <= overflow_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_dsp_chain_sop_param.sv
// Directed bench for dsp_chain_sop_param: default instance plus a 40-bit
// accumulator instance for the overflow case, both driven by the same inputs.
module tb_dsp_chain_sop_param;

  localparam int unsigned NS = 4;
  localparam int unsigned XW = 18;
  localparam int unsigned YW = 19;

  logic              clk;
  logic              reset;
  logic              in_valid, in_first, in_last;
  logic [NS*XW-1:0]  ax, bx;
  logic [NS*YW-1:0]  ay, by;
  logic              out_valid;
  logic [47:0]       result;
  logic              overflow;
  logic              out_valid2;
  logic [39:0]       result2;
  logic              overflow2;

  int n_vec = 0;
  int n_err = 0;

  dsp_chain_sop_param dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_first  (in_first),
    .in_last   (in_last),
    .ax        (ax),
    .bx        (bx),
    .ay        (ay),
    .by        (by),
    .out_valid (out_valid),
    .result    (result),
    .overflow  (overflow)
  );

  dsp_chain_sop_param #(
    .CHAIN_W (40),
    .ACC_W   (40)
  ) dut2 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_first  (in_first),
    .in_last   (in_last),
    .ax        (ax),
    .bx        (bx),
    .ay        (ay),
    .by        (by),
    .out_valid (out_valid2),
    .result    (result2),
    .overflow  (overflow2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; land 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic f, input logic l);
    in_valid = v;
    in_first = f;
    in_last  = l;
  endtask

  // Same operands on every stage.
  task automatic set_ops(input int a, input int b_y, input int c, input int d);
    for (int k = 0; k < NS; k++) begin
      ax[k*XW +: XW] = XW'(a);
      ay[k*YW +: YW] = YW'(b_y);
      bx[k*XW +: XW] = XW'(c);
      by[k*YW +: YW] = YW'(d);
    end
  endtask

  // Expect no output pulse for n cycles, stepping one clock after each check.
  task automatic quiet(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      chk(tag, {63'd0, out_valid}, 64'd0);
      tick();
    end
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    set_ops(0, 0, 0, 0);
    tick();
    tick();

    // Reset state
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_result", {16'd0, result}, 64'd0);
    chk("rst_ovf", {63'd0, overflow}, 64'd0);
    reset = 1'b1;

    // Single-sample frame: 4 stages x (1*2 + 3*4) = 56, out in cycle 5
    set_ops(1, 2, 3, 4);
    drive(1'b1, 1'b1, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0);
    quiet("single_early", 4);
    chk("single_valid", {63'd0, out_valid}, 64'd1);
    chk("single_result", {16'd0, result}, 64'd56);
    chk("single_ovf", {63'd0, overflow}, 64'd0);
    tick();
    chk("single_pulse", {63'd0, out_valid}, 64'd0);
    chk("single_hold", {16'd0, result}, 64'd56);

    // Three-sample frame with two bubbles before the last sample: 3 x 56
    drive(1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0);
    tick();
    tick();
    drive(1'b1, 1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0);
    quiet("frame3_early", 4);
    chk("frame3_valid", {63'd0, out_valid}, 64'd1);
    chk("frame3_result", {16'd0, result}, 64'd168);
    tick();
    chk("frame3_pulse", {63'd0, out_valid}, 64'd0);
    tick();
    chk("frame3_hold", {16'd0, result}, 64'd168);

    // Signed: only stage 0 active, -131072 * 262143
    set_ops(0, 0, 0, 0);
    ax[XW-1:0] = XW'(-131072);
    ay[YW-1:0] = YW'(262143);
    drive(1'b1, 1'b1, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0);
    set_ops(0, 0, 0, 0);
    quiet("signed_early", 4);
    chk("signed_valid", {63'd0, out_valid}, 64'd1);
    chk("signed_result", {16'd0, result}, {16'd0, 48'hFFF8_0002_0000});
    chk("signed_ovf", {63'd0, overflow}, 64'd0);

    // Overflow: two full-scale samples of 2^38 each; 40-bit acc wraps
    set_ops(-131072, -262144, -131072, -262144);
    drive(1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0);
    set_ops(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      chk("ovf_early", {63'd0, out_valid2}, 64'd0);
      tick();
    end
    chk("ovf_valid", {63'd0, out_valid2}, 64'd1);
    chk("ovf_result40", {24'd0, result2}, {24'd0, 40'h80_0000_0000});
    chk("ovf_flag40", {63'd0, overflow2}, 64'd1);
    chk("ovf_result48", {16'd0, result}, {16'd0, 48'h0080_0000_0000});
    chk("ovf_flag48", {63'd0, overflow}, 64'd0);
    tick();
    chk("ovf_flag_hold", {63'd0, overflow2}, 64'd1);

    // Small frame after overflow clears the flag
    set_ops(1, 2, 3, 4);
    drive(1'b1, 1'b1, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    tick();
    chk("clr_valid", {63'd0, out_valid2}, 64'd1);
    chk("clr_result40", {24'd0, result2}, 64'd56);
    chk("clr_flag40", {63'd0, overflow2}, 64'd0);

    // Back-to-back single-sample frames: 56 then 112 (4 x (2*2 + 3*8))
    tick();
    set_ops(1, 2, 3, 4);
    drive(1'b1, 1'b1, 1'b1);
    tick();
    set_ops(2, 2, 3, 8);
    tick();
    drive(1'b0, 1'b0, 1'b0);
    quiet("b2b_early", 3);
    chk("b2b_valid0", {63'd0, out_valid}, 64'd1);
    chk("b2b_result0", {16'd0, result}, 64'd56);
    tick();
    chk("b2b_valid1", {63'd0, out_valid}, 64'd1);
    chk("b2b_result1", {16'd0, result}, 64'd112);
    tick();
    chk("b2b_pulse", {63'd0, out_valid}, 64'd0);
    chk("b2b_hold", {16'd0, result}, 64'd112);

    // Reset mid-frame: samples in cycles 0..2, reset low in cycle 3
    set_ops(1, 2, 3, 4);
    drive(1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    chk("arst_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_result", {16'd0, result}, 64'd0);
    chk("arst_ovf", {63'd0, overflow}, 64'd0);
    chk("arst_result40", {24'd0, result2}, 64'd0);
    tick();
    tick();
    reset = 1'b1;
    quiet("arst_dropped", 8);

    // Fresh frame after release
    set_ops(2, 2, 3, 8);
    drive(1'b1, 1'b1, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0);
    quiet("post_rst_early", 4);
    chk("post_rst_valid", {63'd0, out_valid}, 64'd1);
    chk("post_rst_result", {16'd0, result}, 64'd112);
    chk("post_rst_ovf", {63'd0, overflow}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
